// File: rtl/knn_distance_stream.sv
// Streaming two-stage distance unit: |p-q| per beat, then square-or-pass and accumulate
// DIMENSION beats into one squared-Euclidean or Manhattan distance on a valid/ready output.
module knn_distance_stream #(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned DIMENSION = 3,
  parameter int unsigned ACC_W     = 2 * SIZE + $clog2(DIMENSION)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_p,
  input  logic [SIZE-1:0]  in_q,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] dst,
  output logic             dst_mode
);

  localparam int unsigned CntW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIMENSION - 1);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              vec_mode_q, vec_mode_d;
  logic [SIZE-1:0]   s1_diff_q, s1_diff_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_first_q, s1_first_d;
  logic              s1_last_q, s1_last_d;
  logic              s1_mode_q, s1_mode_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  dst_q, dst_d;
  logic              dst_mode_q, dst_mode_d;
  logic              out_valid_q, out_valid_d;

  logic              stall;
  logic              accept;
  logic              beat_first;
  logic              beat_last;
  logic              cur_mode;
  logic [SIZE-1:0]   diff;
  logic [2*SIZE-1:0] square;
  logic [2*SIZE-1:0] term;
  logic [ACC_W-1:0]  sum;
  logic              s2_fire;

  always_comb begin
    stall      = out_valid_q && !out_ready;
    in_ready   = !stall;
    accept     = in_valid && in_ready;
    beat_first = (cnt_q == '0);
    beat_last  = (cnt_q == CntLast);
    // Mode is latched on beat 0 and held for the rest of the vector.
    cur_mode   = beat_first ? in_mode : vec_mode_q;
    diff       = (in_p >= in_q) ? (in_p - in_q) : (in_q - in_p);
    square     = {{SIZE{1'b0}}, s1_diff_q} * {{SIZE{1'b0}}, s1_diff_q};
    term       = s1_mode_q ? {{SIZE{1'b0}}, s1_diff_q} : square;
    sum        = (s1_first_q ? '0 : acc_q) + ACC_W'(term);
    s2_fire    = !stall && s1_valid_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    vec_mode_d  = vec_mode_q;
    s1_diff_d   = s1_diff_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_mode_d   = s1_mode_q;
    acc_d       = acc_q;
    dst_d       = dst_q;
    dst_mode_d  = dst_mode_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      cnt_d = beat_last ? '0 : cnt_q + CntW'(1);
      if (beat_first) vec_mode_d = in_mode;
    end

    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_diff_d  = diff;
        s1_first_d = beat_first;
        s1_last_d  = beat_last;
        s1_mode_d  = cur_mode;
      end
    end

    if (s2_fire) begin
      acc_d = sum;
    end

    // A completion on the same edge as a handoff keeps out_valid high (no bubble).
    if (s2_fire && s1_last_q) begin
      dst_d       = sum;
      dst_mode_d  = s1_mode_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      vec_mode_q  <= 1'b0;
      s1_diff_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= 1'b0;
      acc_q       <= '0;
      dst_q       <= '0;
      dst_mode_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      vec_mode_q  <= vec_mode_d;
      s1_diff_q   <= s1_diff_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      acc_q       <= acc_d;
      dst_q       <= dst_d;
      dst_mode_q  <= dst_mode_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dst       = dst_q;
  assign dst_mode  = dst_mode_q;

endmodule
